// File: rtl/regfile_scoreboard.sv
// Parametrised register file: muxed read ports with write bypass, a busy
// scoreboard for issue hazards, and a sequential post-reset clear of storage.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int NREAD = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    output logic                     o_init_done,
    input  logic [NREAD*$clog2(NREG)-1:0] i_rd_addr,
    output logic [NREAD*XLEN-1:0]    o_rd_data,
    output logic [NREAD-1:0]         o_rd_busy,
    input  logic                     i_wr_en,
    input  logic [$clog2(NREG)-1:0]  i_wr_addr,
    input  logic [XLEN-1:0]          i_wr_data,
    input  logic                     i_rsv_en,
    input  logic [$clog2(NREG)-1:0]  i_rsv_addr
);

    localparam int SELW = $clog2(NREG);

    localparam logic [0:0] S_INIT = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]      r_state;
    logic [SELW-1:0] r_clr_ptr;
    logic            r_init_done;
    logic [NREG-1:0] r_busy;
    logic [XLEN-1:0] r_mem [NREG];

    logic w_run;
    logic w_wr_req;
    logic w_wr_commit;
    logic w_rsv_commit;

    // Register 0 is hardwired zero; selects at or beyond NREG address nothing.
    function automatic logic f_addr_ok(input logic [SELW-1:0] a);
        return (a != '0) && (32'(a) < 32'(NREG));
    endfunction

    assign w_run        = (r_state == S_RUN);
    assign w_wr_req     = w_run && i_wr_en && f_addr_ok(i_wr_addr);
    assign w_wr_commit  = w_wr_req && !i_reset;
    assign w_rsv_commit = w_run && i_rsv_en && f_addr_ok(i_rsv_addr) && !i_reset;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_INIT;
            r_clr_ptr   <= SELW'(1);
            r_init_done <= 1'b0;
            r_busy      <= '0;
        end else if (r_state == S_INIT) begin
            r_clr_ptr <= r_clr_ptr + SELW'(1);
            if (r_clr_ptr == SELW'(NREG - 1)) begin
                r_state     <= S_RUN;
                r_init_done <= 1'b1;
            end
        end else begin
            if (w_wr_commit) begin
                r_busy[i_wr_addr] <= 1'b0;
            end
            // A new reservation on the register being written wins.
            if (w_rsv_commit) begin
                r_busy[i_rsv_addr] <= 1'b1;
            end
        end
    end

    // Storage carries no reset; the INIT walk zeroes it one entry per cycle.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            if (r_state == S_INIT) begin
                r_mem[r_clr_ptr] <= '0;
            end else if (w_wr_commit) begin
                r_mem[i_wr_addr] <= i_wr_data;
            end
        end
    end

    assign o_init_done = r_init_done;

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [SELW-1:0] w_sel;
        logic [XLEN-1:0] w_data;
        logic            w_busy;

        assign w_sel = i_rd_addr[g*SELW +: SELW];

        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            if (w_run && f_addr_ok(w_sel)) begin
                if (w_wr_req && (i_wr_addr == w_sel)) begin
                    w_data = i_wr_data;
                end else begin
                    w_data = r_mem[w_sel];
                    w_busy = r_busy[w_sel];
                end
            end
        end

        assign o_rd_data[g*XLEN +: XLEN] = w_data;
        assign o_rd_busy[g]              = w_busy;
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: default-parameter instance plus a 16x64, three-port instance.
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Instance A: defaults (32 x 32, two read ports)
    logic        a_reset, a_init_done, a_wr_en, a_rsv_en;
    logic [4:0]  a_ra0, a_ra1, a_wr_addr, a_rsv_addr;
    logic [9:0]  a_rd_addr;
    logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy;
    logic [31:0] a_wr_data;
    assign a_rd_addr = {a_ra1, a_ra0};

    regfile_scoreboard u_a (
        .i_clk       (clk),
        .i_reset     (a_reset),
        .o_init_done (a_init_done),
        .i_rd_addr   (a_rd_addr),
        .o_rd_data   (a_rd_data),
        .o_rd_busy   (a_rd_busy),
        .i_wr_en     (a_wr_en),
        .i_wr_addr   (a_wr_addr),
        .i_wr_data   (a_wr_data),
        .i_rsv_en    (a_rsv_en),
        .i_rsv_addr  (a_rsv_addr)
    );

    // Instance B: 16 x 64, three read ports
    logic         b_reset, b_init_done, b_wr_en, b_rsv_en;
    logic [3:0]   b_ra0, b_ra1, b_ra2, b_wr_addr, b_rsv_addr;
    logic [11:0]  b_rd_addr;
    logic [191:0] b_rd_data;
    logic [2:0]   b_rd_busy;
    logic [63:0]  b_wr_data;
    assign b_rd_addr = {b_ra2, b_ra1, b_ra0};

    regfile_scoreboard #(.XLEN(64), .NREG(16), .NREAD(3)) u_b (
        .i_clk       (clk),
        .i_reset     (b_reset),
        .o_init_done (b_init_done),
        .i_rd_addr   (b_rd_addr),
        .o_rd_data   (b_rd_data),
        .o_rd_busy   (b_rd_busy),
        .i_wr_en     (b_wr_en),
        .i_wr_addr   (b_wr_addr),
        .i_wr_data   (b_wr_data),
        .i_rsv_en    (b_rsv_en),
        .i_rsv_addr  (b_rsv_addr)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int cnt;
        a_reset = 1'b1; a_wr_en = 1'b0; a_rsv_en = 1'b0;
        a_ra0 = '0; a_ra1 = '0; a_wr_addr = '0; a_rsv_addr = '0; a_wr_data = '0;
        b_reset = 1'b1; b_wr_en = 1'b0; b_rsv_en = 1'b0;
        b_ra0 = '0; b_ra1 = '0; b_ra2 = '0; b_wr_addr = '0; b_rsv_addr = '0; b_wr_data = '0;

        // Test 1: init timing and zeroed contents
        cyc(); cyc();
        chk("reset_init_done", 64'(a_init_done), 64'(0));
        a_reset = 1'b0;
        cnt = 0;
        while (!a_init_done && cnt < 100) begin
            cyc();
            cnt++;
        end
        chk("init_cycles", 64'(cnt), 64'(31));
        for (int i = 0; i < 32; i++) begin
            a_ra0 = 5'(i); a_ra1 = 5'(i);
            settle();
            chk("init_zero_data", a_rd_data, 64'(0));
            chk("init_zero_busy", 64'(a_rd_busy), 64'(0));
        end

        // Test 2: write with same-cycle bypass, then stored read
        cyc();
        a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF; a_ra0 = 5'd5; a_ra1 = 5'd6;
        settle();
        chk("bypass_data", 64'(a_rd_data[31:0]), 64'(32'hDEADBEEF));
        chk("bypass_other", 64'(a_rd_data[63:32]), 64'(0));
        cyc();
        a_wr_en = 1'b0;
        settle();
        chk("stored_data", 64'(a_rd_data[31:0]), 64'(32'hDEADBEEF));

        // Test 3: register 0 protection
        cyc();
        a_wr_en = 1'b1; a_wr_addr = 5'd1; a_wr_data = 32'hA5A5A5A5;
        cyc();
        a_wr_addr = 5'd0; a_wr_data = 32'h12345678; a_ra0 = 5'd0; a_ra1 = 5'd0;
        settle();
        chk("x0_bypass", a_rd_data, 64'(0));
        cyc();
        a_wr_en = 1'b0; a_ra1 = 5'd1;
        settle();
        chk("x0_read", 64'(a_rd_data[31:0]), 64'(0));
        chk("x1_kept", 64'(a_rd_data[63:32]), 64'(32'hA5A5A5A5));

        // Test 4: scoreboard
        cyc();
        a_rsv_en = 1'b1; a_rsv_addr = 5'd7; a_ra0 = 5'd7;
        settle();
        chk("rsv_not_yet", 64'(a_rd_busy[0]), 64'(0));
        cyc();
        a_rsv_en = 1'b0;
        settle();
        chk("rsv_busy", 64'(a_rd_busy[0]), 64'(1));
        a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h42;
        settle();
        chk("wb_bypass_busy", 64'(a_rd_busy[0]), 64'(0));
        chk("wb_bypass_data", 64'(a_rd_data[31:0]), 64'(32'h42));
        cyc();
        a_wr_en = 1'b0;
        settle();
        chk("wb_cleared_busy", 64'(a_rd_busy[0]), 64'(0));
        chk("wb_stored", 64'(a_rd_data[31:0]), 64'(32'h42));
        a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h99;
        a_rsv_en = 1'b1; a_rsv_addr = 5'd9; a_ra1 = 5'd9;
        settle();
        chk("rsv_wr_bypass", 64'({a_rd_busy[1], a_rd_data[63:32]}), 64'({1'b0, 32'h99}));
        cyc();
        a_wr_en = 1'b0; a_rsv_en = 1'b0;
        settle();
        chk("rsv_wr_busy", 64'(a_rd_busy[1]), 64'(1));
        chk("rsv_wr_data", 64'(a_rd_data[63:32]), 64'(32'h99));

        // Test 5: reset during RUN
        cyc();
        a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'h1;
        cyc();
        a_wr_addr = 5'd4; a_wr_data = 32'h2;
        cyc();
        a_wr_en = 1'b0; a_rsv_en = 1'b1; a_rsv_addr = 5'd4;
        cyc();
        a_rsv_en = 1'b0; a_ra0 = 5'd4; a_ra1 = 5'd3;
        settle();
        chk("pre_reset_busy4", 64'(a_rd_busy[0]), 64'(1));
        chk("pre_reset_data", a_rd_data, {32'h1, 32'h2});
        a_reset = 1'b1;
        a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'hBAD0BAD0;
        a_rsv_en = 1'b1; a_rsv_addr = 5'd5;
        cyc();
        a_reset = 1'b0;
        settle();
        chk("post_reset_busy", 64'(a_rd_busy), 64'(0));
        chk("post_reset_done", 64'(a_init_done), 64'(0));
        cnt = 0;
        while (!a_init_done && cnt < 100) begin
            cyc();
            cnt++;
            if (cnt == 5) begin
                settle();
                chk("init_read_zero", a_rd_data, 64'(0));
            end
        end
        chk("reinit_cycles", 64'(cnt), 64'(31));
        a_wr_en = 1'b0; a_rsv_en = 1'b0;
        settle();
        chk("reinit_regs", a_rd_data, 64'(0));
        a_ra0 = 5'd5;
        settle();
        chk("reinit_busy5", 64'(a_rd_busy), 64'(0));

        // Test 6: 16 x 64, three ports
        cyc();
        b_reset = 1'b0;
        cnt = 0;
        while (!b_init_done && cnt < 100) begin
            cyc();
            cnt++;
        end
        chk("b_init_cycles", 64'(cnt), 64'(15));
        b_wr_en = 1'b1; b_wr_addr = 4'd15; b_wr_data = 64'hFFFF0000FFFF0000;
        cyc();
        b_wr_en = 1'b0; b_ra0 = 4'd15; b_ra1 = 4'd15; b_ra2 = 4'd15;
        settle();
        chk("b_port0", b_rd_data[63:0], 64'hFFFF0000FFFF0000);
        chk("b_port1", b_rd_data[127:64], 64'hFFFF0000FFFF0000);
        chk("b_port2", b_rd_data[191:128], 64'hFFFF0000FFFF0000);
        b_ra0 = 4'd14; b_ra1 = 4'd7; b_ra2 = 4'd1;
        settle();
        chk("b_alias_14", b_rd_data[63:0], 64'(0));
        chk("b_alias_7", b_rd_data[127:64], 64'(0));
        chk("b_alias_1", b_rd_data[191:128], 64'(0));
        chk("b_busy", 64'(b_rd_busy), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the 32x32 two-read register array: generic width, register count and read-port count.
- Muxed reads replace the tri-state bus, and the block adds write-to-read bypass and a per-register busy scoreboard for issue hazard checks.
- A post-reset sequential clear lets the storage map to inferred RAM/flops without a wide reset.
- Sits between decode/issue (reads, reservations) and writeback (writes).

Parameters:
- XLEN, 32, data width in bits.
- NREG, 32, number of architectural registers (2..2^SELW); register 0 is hardwired zero.
- NREAD, 2, number of independent read ports (1..4).
- SELW, $clog2(NREG), register select width (localparam, derived).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- init_done  out  1  high once the post-reset clear has finished; registered.
- rd_addr  in  NREAD*SELW  read select, port i at bits [i*SELW +: SELW].
- rd_data  out  NREAD*XLEN  read data, port i at bits [i*XLEN +: XLEN]; combinational.
- rd_busy  out  NREAD  port i source has an outstanding reservation; combinational.
- wr_en  in  1  writeback strobe.
- wr_addr  in  SELW  writeback destination.
- wr_data  in  XLEN  writeback value.
- rsv_en  in  1  issue reserves a destination.
- rsv_addr  in  SELW  register to mark busy.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. While reset is sampled high at a rising edge:
  - state <= INIT, clr_ptr <= 1, init_done <= 0.
  - All busy bits <= 0.
  - Register contents are not reset directly.
- FSM states are INIT and RUN.
  - INIT: each cycle write 0 to reg[clr_ptr], clr_ptr++. When clr_ptr == NREG-1 is cleared, go to RUN and set init_done <= 1.
  - INIT length after reset deasserts is exactly NREG-1 cycles (31 for the defaults).
  - RUN: stays in RUN until reset.
- INIT side effects:
  - wr_en and rsv_en are ignored: no storage write, no busy change.
  - Reads return 0 and rd_busy returns 0.
- Write (RUN): if wr_en, wr_addr != 0 and wr_addr < NREG, then reg[wr_addr] <= wr_data at the edge, and busy[wr_addr] is cleared.
- Reservation (RUN): if rsv_en, rsv_addr != 0 and rsv_addr < NREG, then busy[rsv_addr] <= 1.
- Reservation and write to the same register in one cycle: busy ends 1 (the new producer wins); the data write still happens.
- Read port i is zero-latency combinational:
  - addr == 0 or addr >= NREG: rd_data = 0, rd_busy = 0.
  - Bypass: if wr_en, state == RUN and wr_addr == addr (nonzero, in range), then rd_data = wr_data and rd_busy = 0, regardless of busy[addr].
  - Otherwise: rd_data = reg[addr], rd_busy = busy[addr].
- All read ports are independent; the same address on several ports returns identical values.
- Writes to address 0 or out-of-range addresses are silently dropped and do not disturb any other register.
- Reset mid-RUN: busy cleared and INIT restarts from register 1. Contents are unreliable until init_done rises again.
- A write in flight on the same edge as reset is discarded.
- No back-pressure: every request in RUN is accepted in its cycle.

Test Plan:
1. Init timing (defaults): reset high 2 cycles then low -> init_done = 0 for exactly 31 cycles, then 1. Every port then reads 0x00000000 for addresses 0..31 with rd_busy = 0.
2. Write/read: wr_en, wr_addr = 5, wr_data = 0xDEADBEEF. Same cycle, rd_addr0 = 5 -> rd_data0 = 0xDEADBEEF (bypass). Next cycle with wr_en = 0 -> still 0xDEADBEEF.
3. x0 protection: write 0x12345678 to addr 0 -> all ports read 0 at addr 0. Register 1 keeps its prior value 0xA5A5A5A5.
4. Scoreboard sequence:
   - rsv_en for addr 7 -> next cycle rd_busy for addr 7 = 1.
   - While busy, wr_en to 7 with 0x00000042 -> same cycle rd_busy = 0 and rd_data = 0x42; next cycle busy[7] = 0.
   - rsv_en and wr_en to 9 in the same cycle -> busy[9] = 1 afterwards and reg[9] updated.
5. Mid-operation reset: with regs 3 = 0x1 and 4 = 0x2 and busy[4] = 1, assert reset for 1 cycle:
   - All rd_busy = 0 immediately after the reset edge.
   - init_done low for 31 cycles.
   - wr_en to 3 during INIT is ignored.
   - After INIT, reg 3 = 0 and reg 4 = 0.
6. Parameter sweep: NREG = 16, NREAD = 3, XLEN = 64:
   - INIT lasts 15 cycles.
   - Write 0xFFFF0000FFFF0000 to reg 15 -> all three ports return it.
   - Writes to addr 15 do not alias other registers.
